// File: rtl/seq_mantissa_multiplier.sv
// Iterative radix-2 shift-add mantissa multiplier with biased exponent adder.
// One multiplier bit is consumed per clock; start/busy/done handshake to control.
module seq_mantissa_multiplier #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned BIAS           = 127
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [EXP_WIDTH-1:0]            expoent_a_in,
  input  logic [EXP_WIDTH-1:0]            expoent_b_in,
  input  logic [MANTISSA_WIDTH:0]         mantissa_a_in,
  input  logic [MANTISSA_WIDTH:0]         mantissa_b_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [EXP_WIDTH-1:0]            expoent_out,
  output logic [2*(MANTISSA_WIDTH+1)-1:0] result_out,
  output logic                            exp_overflow_out,
  output logic                            exp_underflow_out
);

  localparam int unsigned MW = MANTISSA_WIDTH + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned CW = (MW > 1) ? $clog2(MW) : 1;
  localparam int unsigned SW = EXP_WIDTH + 2;

  localparam logic [CW-1:0] LAST_IT = CW'(MW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [PW-1:0]        mcand_q;
  logic [MW-1:0]        mplier_q;
  logic [PW-1:0]        acc_q;
  logic [PW-1:0]        acc_nxt;
  logic [EXP_WIDTH-1:0] exp_hold_q;
  logic                 ovf_hold_q;
  logic                 unf_hold_q;
  logic [SW-1:0]        exp_sum;
  logic                 accept;
  logic                 last_it;
  logic                 zero_op;

  assign accept  = start_in && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_it = (state_q == S_RUN) && (cnt_q == LAST_IT);
  assign zero_op = (mantissa_a_in == '0) || (mantissa_b_in == '0);

  // Two's-complement sum in EXP_WIDTH+2 bits: sign bit flags underflow, next bit overflow
  assign exp_sum = SW'(expoent_a_in) + SW'(expoent_b_in) - SW'(BIAS);

  // Shifted multiplicand is already aligned to the current multiplier bit
  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_IT) state_d = S_DONE;
      S_DONE:  state_d = start_in ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      busy_out <= (state_d == S_RUN);
      done_out <= (state_d == S_DONE);
    end
  end

  // Operand capture, shift-add iteration and result registration
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q             <= '0;
      mcand_q           <= '0;
      mplier_q          <= '0;
      acc_q             <= '0;
      exp_hold_q        <= '0;
      ovf_hold_q        <= 1'b0;
      unf_hold_q        <= 1'b0;
      result_out        <= '0;
      expoent_out       <= '0;
      exp_overflow_out  <= 1'b0;
      exp_underflow_out <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      mcand_q    <= PW'(mantissa_a_in);
      mplier_q   <= mantissa_b_in;
      acc_q      <= '0;
      exp_hold_q <= zero_op ? '0 : exp_sum[EXP_WIDTH-1:0];
      ovf_hold_q <= !zero_op && !exp_sum[SW-1] && exp_sum[SW-2];
      unf_hold_q <= !zero_op && exp_sum[SW-1];
    end else if (state_q == S_RUN) begin
      cnt_q    <= cnt_q + CW'(1);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nxt;
      if (last_it) begin
        result_out        <= acc_nxt;
        expoent_out       <= exp_hold_q;
        exp_overflow_out  <= ovf_hold_q;
        exp_underflow_out <= unf_hold_q;
      end
    end
  end

endmodule

// File: doc/seq_mantissa_multiplier.md
Name: seq_mantissa_multiplier

Overview:
- Iterative radix-2 shift-add mantissa multiplier with exponent adder for the floating-point multiplier datapath.
- Sits directly upstream of the normalizer.
  - Its raw 2*(MANTISSA_WIDTH+1)-bit product and biased exponent sum are the normalizer's result/exponent inputs.
- Uses one multiplier bit per clock, trading latency for area, with a start/busy/done handshake to the control unit.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 23, stored mantissa width; operands include the hidden bit, so MANTISSA_WIDTH+1 bits each.
- BIAS, 127, exponent bias subtracted from the exponent sum.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request; sampled only in IDLE or DONE.
- expoent_a_in  input  EXP_WIDTH  biased exponent, operand A.
- expoent_b_in  input  EXP_WIDTH  biased exponent, operand B.
- mantissa_a_in  input  MANTISSA_WIDTH+1  operand A mantissa, hidden bit included.
- mantissa_b_in  input  MANTISSA_WIDTH+1  operand B mantissa, hidden bit included.
- busy_out  output  1  high while in RUN.
- done_out  output  1  one-cycle pulse; results valid.
- expoent_out  output  EXP_WIDTH  low EXP_WIDTH bits of expoent_a + expoent_b - BIAS.
- result_out  output  2*(MANTISSA_WIDTH+1)  raw unsigned product, unnormalized.
- exp_overflow_out  output  1  exponent sum - BIAS > 2^EXP_WIDTH - 1.
- exp_underflow_out  output  1  exponent sum - BIAS < 0.

Behaviour:
- Reset (rst_n_in low, asynchronous, any state including mid-RUN):
  - state goes to IDLE; all outputs and internal registers go to 0.
  - An in-flight operation is discarded.
  - No done_out pulse follows reset.
- States and transitions:
  - IDLE: start_in=1 goes to RUN; otherwise stay.
  - RUN: stays for exactly MANTISSA_WIDTH+1 clock edges, then goes to DONE.
  - DONE: lasts one cycle. start_in=1 goes to RUN (back-to-back accept); otherwise goes to IDLE.
- Accept edge (start_in=1 in IDLE/DONE):
  - Latch both mantissas.
  - Clear accumulator and iteration counter.
  - Compute the exponent in EXP_WIDTH+2-bit signed arithmetic and latch expoent, overflow and underflow into holding registers.
- RUN edge i (i = 0..MANTISSA_WIDTH):
  - If multiplier bit i = 1, add the multiplicand shifted left by i into the 2*(MANTISSA_WIDTH+1)-bit accumulator. No carry out is possible.
  - Increment the counter.
  - On the last RUN edge, also register result_out, expoent_out and both flags, and assert done_out.
- Latency: done_out is high in the cycle following the (MANTISSA_WIDTH+1)th RUN edge, i.e. MANTISSA_WIDTH+2 edges after the accept edge (25 with defaults).
- busy_out is high exactly during RUN; done_out is high exactly during DONE.
- result_out, expoent_out and flags hold their values from DONE until the last RUN edge of the next operation. They do not change during RUN.
- start_in during RUN is ignored, with no queuing.
- Operand inputs are sampled only on the accept edge; changes afterwards have no effect.
- Zero operand (either mantissa == 0):
  - Still runs the full latency (fixed-latency contract).
  - result_out = 0, expoent_out = 0, both flags = 0. This matches the downstream zero-result handling.
- Overflow and underflow are mutually exclusive. expoent_out carries the wrapped low bits in either case; the flags are authoritative.

Test Plan:
- Reset then idle: rst_n_in low 3 cycles, start_in=0 → all outputs 0, busy_out=0, no done_out pulse.
- 1.5×1.5: exps 127/127, mantissas 0xC00000/0xC00000, start 1 cycle.
  - → busy_out high 24 cycles.
  - → done_out single pulse 25 edges after accept.
  - → result_out=0x900000000000, expoent_out=127, flags 0.
- Back-to-back: start_in held high through DONE.
  - Operation 1: 1.0×1.0 (0x800000², exps 128/127) → result_out=0x400000000000, expoent_out=128.
  - Operation 2 is accepted in the DONE cycle; busy_out reasserts the next cycle.
- Exponent limits:
  - exps 254/254 → exp_overflow_out=1.
  - exps 1/1 → exp_underflow_out=1, expoent_out=0x83.
  - Zero operand: mantissa_a=0 → result_out=0, expoent_out=0, flags 0.
- Reset mid-RUN and ignored start:
  - Pulse start_in at RUN iteration 5 → ignored; done_out still at edge 25.
  - Assert rst_n_in at iteration 10 of the next operation → immediate IDLE, outputs 0, no done_out pulse.
